// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data memory between two requesters.
//
// Requester 0 (CPU load/store) and requester 1 (loader/DMA/debug) are arbitrated
// round-robin, one memory operation per cycle. A granted access with lock=1 gives
// its requester exclusive back-to-back access until it issues an access with
// lock=0. If the owner stays idle for LOCK_TIMEOUT cycles, the lock is dropped.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   mX_req/we/lock        request, write enable, keep-ownership flag (X = 0, 1)
//   mX_addr/wdata         access address (word index) and write data
//   mX_gnt                access accepted this cycle (combinational)
//   mX_rvalid/rdata       read response, one cycle after the read grant
//   mem_addr/wdata        to memory, driven from the granted requester
//   mem_write/mem_read    to memory, strobes for the granted access
//   mem_rdata             from memory, valid the cycle after mem_read
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        StArb   = 2'd0,
        StLock0 = 2'd1,
        StLock1 = 2'd2
    } state_e;

    // Timer value at which an idle lock is released.
    localparam logic [15:0] TimerMax = 16'(LOCK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        pend_rd_q, pend_rd_d;
    logic        pend_id_q, pend_id_d;
    logic [15:0] timer_q, timer_d;

    logic gnt0, gnt1, gnt_any, sel_lock;

    // Grant decision. Nothing is granted while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StArb: begin
                    if (m0_req && m1_req) begin
                        // Tie goes to the requester that was not granted last.
                        gnt0 = last_grant_q;
                        gnt1 = ~last_grant_q;
                    end else begin
                        gnt0 = m0_req;
                        gnt1 = m1_req;
                    end
                end
                StLock0: gnt0 = m0_req;
                StLock1: gnt1 = m1_req;
                default: ;
            endcase
        end
    end

    assign gnt_any = gnt0 | gnt1;
    assign m0_gnt  = gnt0;
    assign m1_gnt  = gnt1;

    // Memory-side mux; idle bus is all zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        sel_lock  = 1'b0;
        if (gnt0) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_write = m0_we;
            mem_read  = ~m0_we;
            sel_lock  = m0_lock;
        end else if (gnt1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_write = m1_we;
            mem_read  = ~m1_we;
            sel_lock  = m1_lock;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        // Reloaded every cycle so back-to-back reads stream at one per cycle.
        pend_rd_d    = mem_read;
        pend_id_d    = gnt1;

        if (gnt_any) begin
            last_grant_d = gnt1;
        end

        unique case (state_q)
            StArb: begin
                if (gnt_any && sel_lock) begin
                    state_d = gnt1 ? StLock1 : StLock0;
                    timer_d = '0;
                end
            end
            StLock0, StLock1: begin
                if (gnt_any) begin
                    if (sel_lock) begin
                        timer_d = '0;
                    end else begin
                        state_d = StArb;
                    end
                end else if (timer_q == TimerMax) begin
                    // Owner idle too long: hand the memory back to arbitration.
                    state_d = StArb;
                    timer_d = '0;
                end else if (timer_q != 16'hFFFF) begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = StArb;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StArb;
            last_grant_q <= 1'b1;
            pend_rd_q    <= 1'b0;
            pend_id_q    <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pend_rd_q    <= pend_rd_d;
            pend_id_q    <= pend_id_d;
            timer_q      <= timer_d;
        end
    end

    // Read response; gated by reset so a read granted just before reset is dropped.
    assign m0_rvalid = pend_rd_q & ~pend_id_q & ~reset;
    assign m1_rvalid = pend_rd_q & pend_id_q & ~reset;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a read-response scoreboard.
// The stimulus process checks grants and the memory bus each cycle and pushes
// expected read responses; a monitor process pops and checks them.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_lock;
    logic [63:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [63:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [63:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [63:0] m1_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    dmem_arbiter #(
        .ADDR_W      (64),
        .DATA_W      (64),
        .LOCK_TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_lock  (m0_lock),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_lock  (m1_lock),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata (m1_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_write(mem_write),
        .mem_read (mem_read),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory model, reloaded with mem[i] = i while reset is high.
    logic [63:0] mem [64];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 64'(i);
        end else if (mem_write) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
        if (mem_read) mem_rdata <= mem[mem_addr[5:0]];
    end

    int cyc;
    int wr_pulses;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) wr_pulses <= wr_pulses + 1;
    end

    typedef struct {
        logic        id;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_err;
    logic mon_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One cycle: drive inputs, check grant and memory bus, queue the read response.
    task automatic step(input logic rst,
                        input logic r0, input logic w0, input logic l0,
                        input logic [63:0] a0, input logic [63:0] d0,
                        input logic r1, input logic w1, input logic l1,
                        input logic [63:0] a1, input logic [63:0] d1,
                        input logic eg0, input logic eg1, input logic [63:0] ed);
        logic        ewe;
        logic [63:0] eaddr, ewd;
        @(negedge clk);
        reset = rst;
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
        #1;
        ewe   = eg0 ? w0 : (eg1 ? w1 : 1'b0);
        eaddr = eg0 ? a0 : (eg1 ? a1 : 64'd0);
        ewd   = eg0 ? d0 : (eg1 ? d1 : 64'd0);
        chk("m0_gnt", m0_gnt, eg0);
        chk("m1_gnt", m1_gnt, eg1);
        chk("mem_write", mem_write, ewe);
        chk("mem_read", mem_read, (eg0 | eg1) & ~ewe);
        chk("mem_addr", mem_addr, eaddr);
        chk("mem_wdata", mem_wdata, ewd);
        if (rst) begin
            sb.delete();
        end else if (eg0 && !w0) begin
            sb.push_back('{1'b0, ed, cyc + 1});
        end else if (eg1 && !w1) begin
            sb.push_back('{1'b1, ed, cyc + 1});
        end
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0,
             1'b0, 1'b0, 64'd0);
    endtask

    // Response monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (!m0_rvalid) chk("m0_rdata_idle_zero", m0_rdata, 64'd0);
                if (!m1_rvalid) chk("m1_rdata_idle_zero", m1_rdata, 64'd0);
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    chk("m0_rvalid", m0_rvalid, {63'd0, ~e.id});
                    chk("m1_rvalid", m1_rvalid, {63'd0, e.id});
                    chk("rdata", e.id ? m1_rdata : m0_rdata, e.data);
                end else begin
                    chk("m0_rvalid_unexpected", m0_rvalid, 64'd0);
                    chk("m1_rvalid_unexpected", m1_rvalid, 64'd0);
                end
            end
        end
    end

    initial begin
        int wr_before;
        n_checks = 0;
        n_err    = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;

        // Reset with both requesting: no grants, idle bus.
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 64'd6, 64'd0,
             1'b0, 1'b0, 64'd0);
        mon_en = 1'b1;
        idle(1'b1);

        // Single read of addr 5 by m0.
        step(1'b0, 1'b1, 1'b0, 1'b0, 64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0,
             1'b1, 1'b0, 64'd5);
        idle(1'b0);

        // Contention: alternating grants starting with m0.
        idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 64'd10, 64'd0, 1'b1, 1'b0, 1'b0, 64'd20, 64'd0,
                 (i % 2) == 0, (i % 2) == 1, (i % 2) == 0 ? 64'd10 : 64'd20);
        end
        idle(1'b0);

        // Write then read of the same address by m1.
        idle(1'b1);
        wr_before = wr_pulses;
        step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0, 64'd7, 64'hDEAD_BEEF,
             1'b0, 1'b1, 64'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd7, 64'd0,
             1'b0, 1'b1, 64'hDEAD_BEEF);
        idle(1'b0);
        chk("write_pulses", 64'(wr_pulses - wr_before), 64'd1);

        // Lock sequence: m0 locked read then unlocked write, m1 held off.
        idle(1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 64'd3, 64'd0, 1'b1, 1'b0, 1'b0, 64'd30, 64'd0,
             1'b1, 1'b0, 64'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 64'd3, 64'h55, 1'b1, 1'b0, 1'b0, 64'd30, 64'd0,
             1'b1, 1'b0, 64'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd30, 64'd0,
             1'b0, 1'b1, 64'd30);
        idle(1'b0);

        // Lock timeout: owner idle for 4 cycles, m1 granted on the 5th.
        idle(1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 64'd4, 64'd0, 1'b1, 1'b0, 1'b0, 64'd31, 64'd0,
             1'b1, 1'b0, 64'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd31, 64'd0,
                 1'b0, 1'b0, 64'd0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd31, 64'd0,
             1'b0, 1'b1, 64'd31);
        idle(1'b0);

        // Reset mid-read: the m1 read is discarded; first post-reset tie goes to m0.
        idle(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd9, 64'd0,
             1'b0, 1'b1, 64'd9);
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'd11, 64'd0, 1'b1, 1'b0, 1'b0, 64'd9, 64'd0,
             1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 64'd11, 64'd0, 1'b1, 1'b0, 1'b0, 64'd9, 64'd0,
             1'b1, 1'b0, 64'd11);
        idle(1'b0);
        idle(1'b0);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
